fir_out_buffer: RTL and testbench
=================================

FIR_OUT_BUFFER -- requirements
Module: fir_out_buffer

Interface
REQ-001 Parameter DATA_W, default 16, width of one filtered output sample.
REQ-002 Parameter DEPTH, default 4, number of sample slots; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; rst=0 at a rising edge resets the block.
REQ-005 in_valid  input  1  filter output strobe; one new sample per cycle when high; cannot be stalled.
REQ-006 in_data  input  DATA_W  filter output sample, qualified by in_valid.
REQ-007 in_ready  output  1  high when a push this cycle is guaranteed to be stored.
REQ-008 out_valid  output  1  out_data holds the oldest stored sample.
REQ-009 out_data  output  DATA_W  oldest stored sample, first-word-fall-through.
REQ-010 out_ready  input  1  downstream accepts out_data when out_valid=1.
REQ-011 count  output  log2(DEPTH)+1  number of stored samples, 0..DEPTH.
REQ-012 overflow  output  1  sticky flag: at least one sample was dropped.
REQ-013 ovf_clr  input  1  clears overflow.

Function
REQ-014 pop SHALL occur when out_valid=1 and out_ready=1; the oldest sample is removed at that edge.
REQ-015 push SHALL occur when in_valid=1 and either count<DEPTH or pop occurs in the same cycle.
REQ-016 When in_valid=1, count=DEPTH and no pop occurs, the sample SHALL be discarded, buffer contents unchanged, and overflow set at that edge.
REQ-017 in_ready SHALL equal (count<DEPTH) or (out_valid and out_ready), combinationally.
REQ-018 out_valid SHALL equal (count!=0), registered-state derived, no combinational path from in_valid.
REQ-019 Write latency: a sample pushed into an empty buffer at edge N SHALL appear on out_data with out_valid=1 after edge N, i.e. in cycle N+1.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-021 Pop with no push SHALL decrement count; push with no pop SHALL increment count.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-023 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 out_ready=1 with count=0 SHALL have no effect.
REQ-025 ovf_clr=1 SHALL clear overflow at the edge; if an overflow event coincides, overflow SHALL end set (set wins).
REQ-026 Data path SHALL not modify samples: no truncation, sign change or reordering.

Reset
REQ-027 rst=0 at an edge SHALL set count=0, both pointers=0, out_valid=0, overflow=0; in_ready then reads 1.
REQ-028 Reset SHALL override any simultaneous push, pop or ovf_clr; stored data is discarded.
REQ-029 out_data value while out_valid=0 is don't-care; storage array needs no reset.
REQ-030 First push SHALL be accepted at the first edge with rst=1.

Verification
REQ-031 Reset, then push 0x0011,0x0022,0x0033 on consecutive cycles, out_ready=0 -> count=3, out_data=0x0011, out_valid=1, overflow=0.
REQ-032 Continue: out_ready=1 for 3 cycles, no push -> out_data 0x0011,0x0022,0x0033 in order, then count=0, out_valid=0.
REQ-033 Fill to DEPTH=4 with out_ready=0, push 0x00AA -> count=4, in_ready=0, overflow=1, 0x00AA never appears on out_data.
REQ-034 Full buffer, push 0x0055 with out_ready=1 same cycle -> count stays 4, head popped, 0x0055 appears as fourth-next sample, overflow unchanged.
REQ-035 Stream 20 samples 1..20 back-to-back with out_ready=1 throughout -> outputs 1..20 in order, one cycle latency, pointers wrap without loss, count<=1.
REQ-036 Buffer holding 2 samples, overflow=1, assert rst=0 mid-stream with in_valid=1 -> next cycle count=0, out_valid=0, overflow=0; ovf_clr with coincident overflow -> overflow=1.

Source files
------------

// File: rtl/fir_out_buffer.sv
// Output buffer behind a free-running FIR filter. It is a first-word-fall-through FIFO.
// When the buffer is full and nothing is popped, the incoming sample is dropped and a sticky overflow flag is raised.
module fir_out_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              full, pop, push, drop;

  // Handshake decode; a pop frees a slot for a same-cycle push when full
  always_comb begin
    full = (count_q == CNT_W'(DEPTH));
    pop  = (count_q != '0) && out_ready;
    push = in_valid && (!full || pop);
    drop = in_valid && !push;
  end

  // Next-state for pointers, occupancy and the sticky flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    // A coincident drop beats a clear request
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage holds no reset; contents are only observable through the valid count
  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready  = !full || pop;
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Bench for fir_out_buffer: directed scenarios followed by random traffic.
// Every cycle is checked against a queue-based model of the buffer.
module tb_fir_out_buffer;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, out_valid, out_ready, overflow, ovf_clr;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CNT_W-1:0]  count;

  always #5 clk = ~clk;

  fir_out_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  logic [DATA_W-1:0] q[$];
  bit                m_ovf;
  int                n_cmp = 0;
  int                n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge
  task automatic cycle(input bit iv, input logic [DATA_W-1:0] d, input bit ordy,
                       input bit clr, input bit rstv);
    bit pop, push;
    rst = rstv; in_valid = iv; in_data = d; out_ready = ordy; ovf_clr = clr;
    #3;
    check_eq("count", 32'(count), 32'(q.size()));
    check_eq("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check_eq("in_ready", 32'(in_ready), 32'((q.size() < int'(DEPTH)) || (q.size() > 0 && ordy)));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() > 0) check_eq("out_data", 32'(out_data), 32'(q[0]));
    @(posedge clk);
    if (!rstv) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      pop  = (q.size() > 0) && ordy;
      push = iv && ((q.size() < int'(DEPTH)) || pop);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(d);
      if (iv && !push) m_ovf = 1'b1;
      else if (clr)    m_ovf = 1'b0;
    end
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    m_ovf = 1'b0;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Three pushes with downstream stalled
    cycle(1, 16'h0011, 0, 0, 1);
    cycle(1, 16'h0022, 0, 0, 1);
    cycle(1, 16'h0033, 0, 0, 1);
    check_eq("s1_count", 32'(count), 32'd3);
    check_eq("s1_head", 32'(out_data), 32'h11);
    check_eq("s1_ovf", 32'(overflow), 32'd0);
    // Drain them in order
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 1);
    check_eq("s2_count", 32'(count), 32'd0);
    check_eq("s2_valid", 32'(out_valid), 32'd0);

    // Fill, then overflow with 0x00AA
    for (int i = 1; i <= 4; i++) cycle(1, DATA_W'(i), 0, 0, 1);
    cycle(1, 16'h00AA, 0, 0, 1);
    check_eq("s3_count", 32'(count), 32'd4);
    check_eq("s3_in_ready", 32'(in_ready), 32'd0);
    check_eq("s3_ovf", 32'(overflow), 32'd1);

    // Push into a full buffer while popping
    cycle(1, 16'h0055, 1, 0, 1);
    check_eq("s4_count", 32'(count), 32'd4);
    check_eq("s4_head", 32'(out_data), 32'd2);
    check_eq("s4_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 1);
    check_eq("s4_fourth", 32'(out_data), 32'h55);
    cycle(0, '0, 1, 0, 1);

    // Back-to-back stream through the pointer wrap
    for (int i = 1; i <= 20; i++) begin
      cycle(1, DATA_W'(i), 1, 0, 1);
      check_eq("s5_head", 32'(out_data), 32'(i));
      check_eq("s5_cnt_le1", 32'(count <= 1), 32'd1);
    end
    cycle(0, '0, 1, 0, 1);

    // Reset mid-stream with two stored samples and overflow set
    for (int i = 0; i < 5; i++) cycle(1, DATA_W'(16'h100 + i), 0, 0, 1);
    cycle(0, '0, 1, 0, 1);
    cycle(0, '0, 1, 0, 1);
    check_eq("s6_pre_count", 32'(count), 32'd2);
    check_eq("s6_pre_ovf", 32'(overflow), 32'd1);
    cycle(1, 16'h0777, 1, 1, 0);
    check_eq("s6_count", 32'(count), 32'd0);
    check_eq("s6_valid", 32'(out_valid), 32'd0);
    check_eq("s6_ovf", 32'(overflow), 32'd0);
    // Clear coinciding with a drop leaves overflow set
    for (int i = 0; i < 4; i++) cycle(1, DATA_W'(16'h200 + i), 0, 0, 1);
    cycle(1, 16'h0999, 0, 1, 1);
    check_eq("s6_set_wins", 32'(overflow), 32'd1);
    cycle(0, '0, 0, 1, 1);
    check_eq("s6_clr", 32'(overflow), 32'd0);
    // Pop request on an empty buffer does nothing
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0, 1);
    cycle(0, '0, 1, 0, 1);
    check_eq("s7_empty_count", 32'(count), 32'd0);

    // Random traffic with occasional clears and resets
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), DATA_W'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 63) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
